// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - FSM state encoding and hazard control bundle shared by pipeline_ctrl
package pipeline_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic id_stall;
    logic ifid_flush;
    logic idex_flush;
  } haz_ctrl_t;

  // Pipeline frozen: nothing written, ID held, nothing flushed.
  localparam haz_ctrl_t HAZ_FROZEN   = '{pc_we: 1'b0, ifid_we: 1'b0, id_stall: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam haz_ctrl_t HAZ_REDIRECT = '{pc_we: 1'b1, ifid_we: 1'b1, id_stall: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam haz_ctrl_t HAZ_LOAD_USE = '{pc_we: 1'b0, ifid_we: 1'b0, id_stall: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam haz_ctrl_t HAZ_ADVANCE  = '{pc_we: 1'b1, ifid_we: 1'b1, id_stall: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and branch/jump redirect detection
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR = 5
) (
  input  logic               pipe_en,
  input  logic [NB_ADDR-1:0] id_rs,
  input  logic [NB_ADDR-1:0] id_rt,
  input  logic [NB_ADDR-1:0] ex_rt,
  input  logic               ex_mem_read,
  input  logic               branch_taken,
  input  logic               jump,
  output haz_ctrl_t          ctrl
);

  logic load_use;
  logic redirect;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign redirect = branch_taken || jump;

  always_comb begin
    ctrl = HAZ_FROZEN;
    if (pipe_en) begin
      if (redirect) begin
        ctrl = HAZ_REDIRECT;
      end else if (load_use) begin
        ctrl = HAZ_LOAD_USE;
      end else begin
        ctrl = HAZ_ADVANCE;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - run/step/halt pipeline control FSM; step mode built only with PIPELINE_CTRL_STEP_EN
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic               i_ex_memRead,
  input  logic               i_branch_taken,
  input  logic               i_jump,
  input  logic               i_halt_wb,
  input  logic               i_dbg_start,
  input  logic               i_dbg_mode,
  input  logic               i_dbg_step,
  output logic               o_pipe_en,
  output logic               o_pc_we,
  output logic               o_ifid_we,
  output logic               o_id_stall,
  output logic               o_ifid_flush,
  output logic               o_idex_flush,
  output logic               o_done,
  output logic [1:0]         o_state,
  output logic [NB_CNT-1:0]  o_cycle_cnt
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        start_target;
  logic              pipe_en;
  logic [NB_CNT-1:0] cycle_cnt;
  haz_ctrl_t         ctrl;

`ifdef PIPELINE_CTRL_STEP_EN
  logic step_q;

  // A step pulse opens exactly the following cycle; consecutive pulses chain naturally.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= (state == ST_STEP) && i_dbg_step;
    end
  end

  assign pipe_en      = (state == ST_RUN) || ((state == ST_STEP) && step_q);
  assign start_target = i_dbg_mode ? ST_STEP : ST_RUN;
`else
  logic unused_dbg;

  assign unused_dbg   = i_dbg_mode ^ i_dbg_step;
  assign pipe_en      = (state == ST_RUN);
  assign start_target = ST_RUN;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_dbg_start) begin
          state_nxt = start_target;
        end
      end
      ST_RUN, ST_STEP: begin
        if (pipe_en && i_halt_wb) begin
          state_nxt = ST_HALTED;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt <= '0;
    end else if (pipe_en && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + {{(NB_CNT-1){1'b0}}, 1'b1};
    end
  end

  hazard_detect #(
    .NB_ADDR(NB_ADDR)
  ) u_hazard_detect (
    .pipe_en     (pipe_en),
    .id_rs       (i_id_rs),
    .id_rt       (i_id_rt),
    .ex_rt       (i_ex_rt),
    .ex_mem_read (i_ex_memRead),
    .branch_taken(i_branch_taken),
    .jump        (i_jump),
    .ctrl        (ctrl)
  );

  assign o_pipe_en    = pipe_en;
  assign o_pc_we      = ctrl.pc_we;
  assign o_ifid_we    = ctrl.ifid_we;
  assign o_id_stall   = ctrl.id_stall;
  assign o_ifid_flush = ctrl.ifid_flush;
  assign o_idex_flush = ctrl.idex_flush;
  assign o_done       = (state == ST_HALTED);
  assign o_state      = state;
  assign o_cycle_cnt  = cycle_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl (step tests active with PIPELINE_CTRL_STEP_EN)
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        mem_read = 1'b0, br = 1'b0, jmp = 1'b0, halt = 1'b0;
  logic        start = 1'b0, mode = 1'b0, step = 1'b0;

  logic        pipe_en, pc_we, ifid_we, id_stall, ifid_flush, idex_flush, done;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic        pipe_en4, pc_we4, ifid_we4, id_stall4, ifid_flush4, idex_flush4, done4;
  logic [1:0]  state4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NB_ADDR(5), .NB_CNT(32)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
    .i_ex_memRead(mem_read), .i_branch_taken(br), .i_jump(jmp), .i_halt_wb(halt),
    .i_dbg_start(start), .i_dbg_mode(mode), .i_dbg_step(step),
    .o_pipe_en(pipe_en), .o_pc_we(pc_we), .o_ifid_we(ifid_we), .o_id_stall(id_stall),
    .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush), .o_done(done),
    .o_state(state), .o_cycle_cnt(cnt)
  );

  pipeline_ctrl #(.NB_ADDR(5), .NB_CNT(4)) dut4 (
    .clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
    .i_ex_memRead(mem_read), .i_branch_taken(br), .i_jump(jmp), .i_halt_wb(halt),
    .i_dbg_start(start), .i_dbg_mode(mode), .i_dbg_step(step),
    .o_pipe_en(pipe_en4), .o_pc_we(pc_we4), .o_ifid_we(ifid_we4), .o_id_stall(id_stall4),
    .o_ifid_flush(ifid_flush4), .o_idex_flush(idex_flush4), .o_done(done4),
    .o_state(state4), .o_cycle_cnt(cnt4)
  );

  typedef struct {
    int         rs;
    int         rt;
    int         ext;
    logic       mr;
    logic       b;
    logic       j;
    logic [4:0] exp;
    logic [4:0] care;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    mem_read = 1'b0; br = 1'b0; jmp = 1'b0; halt = 1'b0;
    start = 1'b0; mode = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic start_pulse(input logic m);
    start = 1'b1; mode = m;
    tick();
    start = 1'b0; mode = 1'b0;
  endtask

  // Output order: {pc_we, ifid_we, id_stall, ifid_flush, idex_flush}
  function automatic logic [4:0] ref_haz(input logic en, input int rs, input int rt, input int ext,
                                         input logic mr, input logic b, input logic j,
                                         output logic [4:0] care);
    logic lu;
    lu = mr && (ext != 0) && (ext == rs || ext == rt);
    care = 5'b11111;
    if (!en) return 5'b00100;
    if (b || j) begin
      care = 5'b10111;
      return 5'b10011;
    end
    if (lu) begin
      care = 5'b11101;
      return 5'b00101;
    end
    return 5'b11000;
  endfunction

  function automatic logic [4:0] got_haz();
    return {pc_we, ifid_we, id_stall, ifid_flush, idex_flush};
  endfunction

  task automatic apply(input int rs, input int rt, input int ext, input logic mr, input logic b, input logic j);
    id_rs = 5'(rs); id_rt = 5'(rt); ex_rt = 5'(ext);
    mem_read = mr; br = b; jmp = j;
  endtask

  initial begin
    logic [4:0] exp_h, care;
    int n_en;
    int rs, rt, ext;
    logic mr, b, j;

    vecs[0] = '{rs: 5, rt: 0, ext: 5, mr: 1, b: 0, j: 0, exp: 5'b00101, care: 5'b11101};
    vecs[1] = '{rs: 5, rt: 0, ext: 0, mr: 1, b: 0, j: 0, exp: 5'b11000, care: 5'b11111};
    vecs[2] = '{rs: 3, rt: 5, ext: 5, mr: 1, b: 0, j: 0, exp: 5'b00101, care: 5'b11101};
    vecs[3] = '{rs: 5, rt: 0, ext: 5, mr: 1, b: 1, j: 0, exp: 5'b10011, care: 5'b10111};
    vecs[4] = '{rs: 5, rt: 5, ext: 5, mr: 0, b: 0, j: 0, exp: 5'b11000, care: 5'b11111};
    vecs[5] = '{rs: 1, rt: 2, ext: 3, mr: 0, b: 0, j: 1, exp: 5'b10011, care: 5'b10111};
    vecs[6] = '{rs: 7, rt: 7, ext: 6, mr: 1, b: 0, j: 0, exp: 5'b11000, care: 5'b11111};
    vecs[7] = '{rs: 0, rt: 0, ext: 0, mr: 1, b: 0, j: 0, exp: 5'b11000, care: 5'b11111};

    // Reset state
    do_reset();
    chk("reset_state", state, 0);
    chk("reset_pipe_en", pipe_en, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_haz", got_haz(), 5'b00100);

    // IDLE ignores everything but start
    halt = 1'b1; step = 1'b1; br = 1'b1; mem_read = 1'b1;
    repeat (3) tick();
    clear_inputs();
    chk("idle_hold_state", state, 0);
    chk("idle_hold_cnt", cnt, 0);

    // Run, halt after 10 cycles
    start_pulse(1'b0);
    chk("run_state", state, 1);
    chk("run_pipe_en", pipe_en, 1);
    repeat (10) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_state", state, 3);
    chk("halt_cnt", cnt, 11);
    chk("halt_done", done, 1);
    chk("halt_pipe_en", pipe_en, 0);
    chk("halt_cnt4", cnt4, 11);
    start_pulse(1'b0);
    tick();
    chk("halted_sticky_state", state, 3);
    chk("halted_sticky_cnt", cnt, 11);

    // Hazard vector table in RUN
    do_reset();
    start_pulse(1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].rs, vecs[i].rt, vecs[i].ext, vecs[i].mr, vecs[i].b, vecs[i].j);
      #1;
      chk($sformatf("vec%0d_haz", i), got_haz() & vecs[i].care, vecs[i].exp & vecs[i].care);
      tick();
    end
    chk("vec_cnt", cnt, 8);

    // Randomized hazards in IDLE (pipeline disabled)
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rs = int'($urandom_range(0, 3)); rt = int'($urandom_range(0, 3)); ext = int'($urandom_range(0, 3));
      mr = 1'($urandom); b = ($urandom_range(0, 3) == 0); j = ($urandom_range(0, 3) == 0);
      apply(rs, rt, ext, mr, b, j);
      #1;
      exp_h = ref_haz(1'b0, rs, rt, ext, mr, b, j, care);
      chk("rand_idle_haz", got_haz() & care, exp_h & care);
      tick();
    end

    // Randomized hazards in RUN, counter tracked by cycle tally
    do_reset();
    start_pulse(1'b0);
    n_en = 0;
    for (int i = 0; i < 200; i++) begin
      rs = int'($urandom_range(0, 3)); rt = int'($urandom_range(0, 3)); ext = int'($urandom_range(0, 3));
      mr = 1'($urandom); b = ($urandom_range(0, 3) == 0); j = ($urandom_range(0, 5) == 0);
      apply(rs, rt, ext, mr, b, j);
      #1;
      exp_h = ref_haz(1'b1, rs, rt, ext, mr, b, j, care);
      chk("rand_run_haz", got_haz() & care, exp_h & care);
      tick();
      n_en++;
    end
    chk("rand_run_cnt", cnt, n_en);
    chk("rand_run_cnt4", cnt4, (n_en > 15) ? 15 : n_en);

    // Small counter saturation
    do_reset();
    start_pulse(1'b0);
    repeat (20) tick();
    chk("sat_cnt4", cnt4, 15);
    chk("sat_cnt32", cnt, 20);
    tick();
    chk("sat_cnt4_held", cnt4, 15);

`ifdef PIPELINE_CTRL_STEP_EN
    begin
      logic steps[10];
      logic prev;
      int   en_count;
      steps = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0};
      do_reset();
      start_pulse(1'b1);
      chk("step_state", state, 2);
      chk("step_idle_en", pipe_en, 0);
      prev = 1'b0;
      en_count = 0;
      for (int i = 0; i < 10; i++) begin
        step = steps[i];
        #1;
        chk($sformatf("step_en_c%0d", i), pipe_en, prev);
        en_count += int'(pipe_en);
        prev = steps[i];
        tick();
      end
      step = 1'b0;
      chk("step_en_count", en_count, 3);
      chk("step_cnt", cnt, 3);

      // Halt only counts when sampled in an enabled cycle
      halt = 1'b1;
      tick();
      chk("step_halt_ignored", state, 2);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_halt_en", pipe_en, 1);
      tick();
      halt = 1'b0;
      chk("step_halt_state", state, 3);
      chk("step_halt_cnt", cnt, 4);

      // Random step pulses: enabled exactly the cycle after each pulse
      do_reset();
      start_pulse(1'b1);
      prev = 1'b0;
      en_count = 0;
      for (int i = 0; i < 60; i++) begin
        step = ($urandom_range(0, 2) == 0);
        #1;
        chk("rand_step_en", pipe_en, prev);
        en_count += int'(prev);
        prev = step;
        tick();
      end
      step = 1'b0;
      en_count += int'(prev);
      tick();
      chk("rand_step_cnt", cnt, en_count);

      // Reset mid-step discards the pending step
      do_reset();
      start_pulse(1'b1);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("mid_step_en", pipe_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_en", pipe_en, 0);
      chk("mid_rst_cnt", cnt, 0);
      tick();
      rst_n = 1'b1;
      en_count = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        en_count += int'(pipe_en);
        tick();
      end
      chk("post_rst_en_count", en_count, 0);
      chk("post_rst_cnt", cnt, 0);
      chk("post_rst_state", state, 0);
    end
`else
    do_reset();
    start_pulse(1'b1);
    chk("nostep_state", state, 1);
    chk("nostep_en", pipe_en, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("nostep_cnt", cnt, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter NB_ADDR, default 5, register address width.
REQ-002 The block SHALL have parameter NB_CNT, default 32, cycle counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and i_rst_n.
REQ-004 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-005 The block SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port i_id_rs  input  NB_ADDR  rs of the instruction in ID.
REQ-007 The block SHALL have port i_id_rt  input  NB_ADDR  rt of the instruction in ID.
REQ-008 The block SHALL have port i_ex_rt  input  NB_ADDR  rt of the instruction in EX.
REQ-009 The block SHALL have port i_ex_memRead  input  1  the instruction in EX is a load.
REQ-010 The block SHALL have port i_branch_taken  input  1  branch resolved taken in EX.
REQ-011 The block SHALL have port i_jump  input  1  jump resolved in EX.
REQ-012 The block SHALL have port i_halt_wb  input  1  HALT instruction reached WB.
REQ-013 The block SHALL have port i_dbg_start  input  1  single-cycle pulse that starts execution.
REQ-014 The block SHALL have port i_dbg_mode  input  1  0 = continuous, 1 = step; sampled on start.
REQ-015 The block SHALL have port i_dbg_step  input  1  single-cycle pulse that advances one cycle.
REQ-016 The block SHALL have outputs o_pipe_en, o_pc_we, o_ifid_we, o_id_stall, o_ifid_flush, o_idex_flush and o_done, each 1 bit.
REQ-017 The block SHALL have outputs o_state (2 bits, FSM state) and o_cycle_cnt (NB_CNT bits, enabled-cycle count).

Function
REQ-018 The FSM SHALL have states IDLE=0, RUN=1, STEP=2 and HALTED=3.
REQ-019 In IDLE, i_dbg_start SHALL move the FSM to RUN when i_dbg_mode=0 and to STEP when i_dbg_mode=1; all other inputs SHALL be ignored.
REQ-020 In RUN, o_pipe_en SHALL be 1 every cycle.
REQ-021 In STEP, o_pipe_en SHALL be 1 for exactly the one cycle after each i_dbg_step pulse and 0 otherwise.
REQ-022 In STEP, back-to-back i_dbg_step pulses SHALL each produce one enabled cycle.
REQ-023 In RUN or STEP, i_halt_wb sampled while o_pipe_en=1 SHALL move the FSM to HALTED on the next edge.
REQ-024 HALTED SHALL be sticky until reset; o_done=1 and o_pipe_en=0 in HALTED, and i_dbg_start SHALL be ignored there.
REQ-025 Load-use (comb.) SHALL be i_ex_memRead && i_ex_rt!=0 && (i_ex_rt==i_id_rs || i_ex_rt==i_id_rt).
REQ-026 With o_pipe_en=1 and load-use and no redirect: o_pc_we=0, o_ifid_we=0, o_id_stall=1, o_idex_flush=1.
REQ-027 With o_pipe_en=1 and i_branch_taken|i_jump (redirect): o_pc_we=1, o_ifid_flush=1, o_idex_flush=1, o_id_stall=0.
REQ-028 Redirect SHALL take priority over load-use when both occur in the same cycle.
REQ-029 With o_pipe_en=1 and neither hazard: o_pc_we=1, o_ifid_we=1, all flush and stall outputs 0.
REQ-030 With o_pipe_en=0: o_pc_we=0, o_ifid_we=0, o_id_stall=1, flush outputs 0.
REQ-031 o_cycle_cnt SHALL increment once per cycle with o_pipe_en=1 and saturate at all-ones.

Reset
REQ-032 Asserting i_rst_n low SHALL immediately force state IDLE, o_cycle_cnt=0, the step pulse register to 0 and o_done=0.
REQ-033 Reset in any state, including mid-step, SHALL discard any pending step.

Configuration
REQ-034 The block SHALL compile step mode in or out with the macro PIPELINE_CTRL_STEP_EN.
REQ-035 With PIPELINE_CTRL_STEP_EN defined, STEP SHALL behave per REQ-021 and REQ-022.
REQ-036 With PIPELINE_CTRL_STEP_EN undefined, i_dbg_mode and i_dbg_step SHALL be ignored, i_dbg_start SHALL always lead to RUN, STEP SHALL be unreachable and no step register SHALL be built.

Structure
REQ-037 The state encoding constants SHALL live in the shared package pipeline_pkg.
REQ-038 The load-use/redirect logic SHALL be a combinational sub-module, hazard_detect.

Verification
REQ-039 Start with mode=0, then i_halt_wb pulse after 10 cycles -> state RUN→HALTED, o_cycle_cnt=11, o_done=1.
REQ-040 In RUN, i_ex_memRead=1, i_ex_rt=5, i_id_rs=5 -> o_pc_we=0, o_id_stall=1, o_idex_flush=1; with i_ex_rt=0 -> no stall.
REQ-041 Load-use plus i_branch_taken=1 in the same cycle -> o_pc_we=1, o_ifid_flush=1, o_id_stall=0.
REQ-042 Mode=1 with 3 step pulses, one gapped and two back-to-back -> exactly 3 o_pipe_en cycles, o_cycle_cnt=3.
REQ-043 Reset asserted mid-STEP after a step pulse -> state IDLE, o_pipe_en=0, o_cycle_cnt=0, with no enabled cycle after release.
REQ-044 With NB_CNT=4 in RUN for 20 cycles -> o_cycle_cnt=15 and held.
